alu_op_dispatcher: RTL and testbench

- Upstream front-end of the ALU control unit.
- Accepts operation requests on a valid/ready interface and buffers one pending request.
- Screens illegal requests, launches the control unit with a one-cycle begin_signal and stable op/operands, and waits for end_signal.
- Captures the datapath result and returns it on a valid/ready response interface with a tag and error code, guarded by a watchdog timeout.

---
 rtl/alu_op_dispatcher.sv | 135 +++++++++++++
 tb/tb_alu_op_dispatcher.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_dispatcher.sv
// Front end of the ALU control unit. It buffers one request and screens out illegal ops.
// It then pulses begin_signal, waits for end_signal under a watchdog, and returns the result.
module alu_op_dispatcher #(
    parameter int W       = 8,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [W-1:0]     req_x,
    input  logic [W-1:0]     req_y,
    input  logic [TAG_W-1:0] req_tag,
    output logic             begin_signal,
    output logic [2:0]       op,
    output logic [W-1:0]     opnd_x,
    output logic [W-1:0]     opnd_y,
    input  logic             end_signal,
    input  logic [W-1:0]     res_a,
    input  logic [W-1:0]     res_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2*W-1:0]   rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_err,
    output logic             busy
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] OP_DIV  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;
    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_ILL = 2'b01;
    localparam logic [1:0] ERR_DZ  = 2'b10;
    localparam logic [1:0] ERR_TO  = 2'b11;

    typedef struct packed {
        logic [2:0]       op;
        logic [W-1:0]     x;
        logic [W-1:0]     y;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t           state;
    req_t             pend;
    logic             pend_valid;
    logic [CNT_W-1:0] to_cnt;

    assign req_ready = ~pend_valid;
    assign busy      = (state != IDLE) | pend_valid;

    // The entry is released when IDLE takes it, so a new request can land during BUSY/RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend       <= '0;
        end else if (req_valid && !pend_valid) begin
            pend_valid <= 1'b1;
            pend.op    <= req_op;
            pend.x     <= req_x;
            pend.y     <= req_y;
            pend.tag   <= req_tag;
        end else if (state == IDLE) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            begin_signal <= 1'b0;
            op           <= '0;
            opnd_x       <= '0;
            opnd_y       <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_tag      <= '0;
            rsp_err      <= ERR_OK;
            to_cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (pend_valid) begin
                    op      <= pend.op;
                    opnd_x  <= pend.x;
                    opnd_y  <= pend.y;
                    rsp_tag <= pend.tag;
                    if (pend.op == OP_ILL) begin
                        rsp_err    <= ERR_ILL;
                        rsp_result <= '0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (pend.op == OP_DIV && pend.y == '0) begin
                        rsp_err    <= ERR_DZ;
                        rsp_result <= '0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        begin_signal <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    begin_signal <= 1'b0;
                    to_cnt       <= '0;
                    state        <= BUSY;
                end
                // end_signal is checked first so a completion on the last allowed cycle still counts.
                BUSY: begin
                    to_cnt <= to_cnt + CNT_W'(1);
                    if (end_signal) begin
                        rsp_result <= {res_a, res_q};
                        rsp_err    <= ERR_OK;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (to_cnt == CNT_LAST) begin
                        rsp_result <= '0;
                        rsp_err    <= ERR_TO;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Bench for alu_op_dispatcher: the main thread drives requests and models the control unit.
// A monitor scores every response handshake against a queue of expected responses.
module tb_alu_op_dispatcher;
    localparam int W       = 8;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready;
    logic [2:0]       req_op;
    logic [W-1:0]     req_x, req_y;
    logic [TAG_W-1:0] req_tag;
    logic             begin_signal;
    logic [2:0]       op;
    logic [W-1:0]     opnd_x, opnd_y;
    logic             end_signal;
    logic [W-1:0]     res_a, res_q;
    logic             rsp_valid, rsp_ready;
    logic [2*W-1:0]   rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       rsp_err;
    logic             busy;

    typedef struct packed {
        logic [2*W-1:0]   result;
        logic [TAG_W-1:0] tag;
        logic [1:0]       err;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   beg_cnt = 0;

    always #5 clk = ~clk;

    alu_op_dispatcher #(.W(W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
        .begin_signal(begin_signal), .op(op), .opnd_x(opnd_x), .opnd_y(opnd_y),
        .end_signal(end_signal), .res_a(res_a), .res_q(res_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_req(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [TAG_W-1:0] t);
        req_valid = 1'b1;
        req_op    = o;
        req_x     = x;
        req_y     = y;
        req_tag   = t;
    endtask

    task automatic expect_rsp(input logic [2*W-1:0] r, input logic [TAG_W-1:0] t, input logic [1:0] e);
        rsp_t v;
        v.result = r;
        v.tag    = t;
        v.err    = e;
        sb_q.push_back(v);
    endtask

    // Monitor: count begin pulses and score each response handshake.
    initial begin
        rsp_t exp_r;
        forever begin
            @(negedge clk);
            if (begin_signal) beg_cnt++;
            if (rsp_valid && rsp_ready) begin
                chk("rsp_pending", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    exp_r = sb_q.pop_front();
                    chk("rsp", 32'({rsp_result, rsp_tag, rsp_err}), 32'(exp_r));
                end
            end
        end
    end

    initial begin
        int bad;
        int b0;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0; req_tag = '0;
        end_signal = 1'b0; res_a = '0; res_q = '0; rsp_ready = 1'b1;
        ticks(2);
        reset = 1'b0;
        chk("rst_out", 32'({begin_signal, op, opnd_x, opnd_y, rsp_valid, rsp_err}), 32'd0);
        chk("rst_res", 32'({rsp_result, rsp_tag}), 32'd0);
        chk("rst_rdy", 32'({req_ready, busy}), 32'b10);
        tick();

        // MUL 13*11, end_signal 40 cycles after begin
        drive_req(3'b101, 8'd13, 8'd11, 4'd3); expect_rsp(16'h008F, 4'd3, 2'b00);
        tick(); req_valid = 1'b0;
        chk("t1_beg_c1", 32'(begin_signal), 32'd0);
        tick();
        chk("t1_beg_c2", 32'(begin_signal), 32'd1);
        chk("t1_issue", 32'({op, opnd_x, opnd_y}), 32'({3'b101, 8'd13, 8'd11}));
        tick();
        bad = 0;
        for (int c = 3; c < 42; c++) begin
            res_a = 8'(c); res_q = 8'(c + 1);
            if ({op, opnd_x, opnd_y} != {3'b101, 8'd13, 8'd11} || begin_signal || rsp_valid) bad++;
            tick();
        end
        chk("t1_hold", 32'(bad), 32'd0);
        end_signal = 1'b1; res_a = 8'h00; res_q = 8'h8F;
        tick(); end_signal = 1'b0; res_a = 8'hFF; res_q = 8'hFF;
        chk("t1_rsp_c43", 32'({rsp_valid, rsp_result}), 32'({1'b1, 16'h008F}));
        tick();
        chk("t1_idle", 32'({rsp_valid, busy}), 32'd0);

        // illegal op, then divide by zero
        drive_req(3'b111, 8'd1, 8'd2, 4'd5); expect_rsp(16'h0000, 4'd5, 2'b01);
        tick(); req_valid = 1'b0;
        chk("t2_ill_c1", 32'(rsp_valid), 32'd0);
        tick();
        chk("t2_ill_c2", 32'({rsp_valid, begin_signal, rsp_err}), 32'b1001);
        tick();
        drive_req(3'b110, 8'd20, 8'd0, 4'd6); expect_rsp(16'h0000, 4'd6, 2'b10);
        tick(); req_valid = 1'b0;
        tick();
        chk("t2_dz_c2", 32'({rsp_valid, begin_signal, rsp_err}), 32'b1010);
        tick();
        chk("t2_no_begin", 32'(beg_cnt), 32'd1);

        // DIV held in BUSY; ADD buffered meanwhile; a third request refused
        drive_req(3'b110, 8'd100, 8'd7, 4'd1); expect_rsp(16'h020E, 4'd1, 2'b00);
        tick(); req_valid = 1'b0;
        ticks(3);
        chk("t3_ready_busy", 32'(req_ready), 32'd1);
        drive_req(3'b011, 8'd3, 8'd4, 4'd9); expect_rsp(16'h0007, 4'd9, 2'b00);
        tick();
        drive_req(3'b000, 8'hFF, 8'h0F, 4'd12);
        chk("t3_ready_full", 32'({req_ready, busy}), 32'b01);
        ticks(3); req_valid = 1'b0;
        ticks(2);
        end_signal = 1'b1; res_a = 8'd2; res_q = 8'd14;
        tick(); end_signal = 1'b0;
        chk("t3_div_rsp", 32'(rsp_valid), 32'd1);
        tick();
        chk("t3_gap", 32'({rsp_valid, begin_signal, req_ready}), 32'b000);
        tick();
        chk("t3_add_beg", 32'({begin_signal, op, opnd_x, opnd_y}), 32'({1'b1, 3'b011, 8'd3, 8'd4}));
        tick();
        end_signal = 1'b1; res_a = 8'd0; res_q = 8'd7;
        tick(); end_signal = 1'b0;
        chk("t3_add_rsp", 32'(rsp_valid), 32'd1);
        tick();
        chk("t3_begins", 32'(beg_cnt), 32'd3);

        // watchdog timeout, then a late end pulse
        drive_req(3'b010, 8'd5, 8'd3, 4'd7); expect_rsp(16'h0000, 4'd7, 2'b11);
        tick(); req_valid = 1'b0;
        ticks(65);
        chk("t4_c66", 32'(rsp_valid), 32'd0);
        tick();
        chk("t4_to", 32'({rsp_valid, rsp_err, rsp_result}), 32'({1'b1, 2'b11, 16'h0000}));
        tick();
        end_signal = 1'b1; res_a = 8'hAA; res_q = 8'h55;
        tick(); end_signal = 1'b0;
        chk("t4_late", 32'({rsp_valid, busy, rsp_result}), 32'd0);
        ticks(3);
        chk("t4_quiet", 32'({rsp_valid, begin_signal}), 32'd0);

        // consumer stalls 10 cycles; a spurious end pulse arrives in RESP
        drive_req(3'b001, 8'hF0, 8'h0F, 4'd10); expect_rsp(16'h00FF, 4'd10, 2'b00);
        tick(); req_valid = 1'b0;
        ticks(9);
        end_signal = 1'b1; res_a = 8'h00; res_q = 8'hFF; rsp_ready = 1'b0;
        tick(); end_signal = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            end_signal = (i == 2);
            res_a = 8'h12; res_q = 8'h34;
            if ({rsp_valid, rsp_result, rsp_tag, rsp_err} != {1'b1, 16'h00FF, 4'd10, 2'b00}) bad++;
            tick();
        end
        end_signal = 1'b0;
        chk("t5_hold", 32'(bad), 32'd0);
        chk("t5_still", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        tick();
        chk("t5_done", 32'(rsp_valid), 32'd0);

        // end_signal on the same cycle the watchdog expires
        drive_req(3'b100, 8'd9, 8'd4, 4'd11); expect_rsp(16'h0005, 4'd11, 2'b00);
        tick(); req_valid = 1'b0;
        ticks(65);
        end_signal = 1'b1; res_a = 8'd0; res_q = 8'd5;
        tick(); end_signal = 1'b0;
        chk("t5_coinc", 32'({rsp_valid, rsp_err}), 32'b100);
        tick();

        // reset in BUSY cycle 5 with a request pending
        drive_req(3'b000, 8'hAA, 8'h0F, 4'd13);
        tick(); req_valid = 1'b0;
        ticks(3);
        drive_req(3'b011, 8'd1, 8'd1, 4'd14);
        tick(); req_valid = 1'b0;
        chk("t6_pend", 32'({req_ready, busy}), 32'b01);
        ticks(2);
        reset = 1'b1;
        tick(); reset = 1'b0;
        chk("t6_rst_out", 32'({begin_signal, op, opnd_x, opnd_y, rsp_valid, rsp_err}), 32'd0);
        chk("t6_rst_res", 32'({rsp_result, rsp_tag}), 32'd0);
        chk("t6_rst_rdy", 32'({req_ready, busy}), 32'b10);
        b0 = beg_cnt;
        ticks(80);
        chk("t6_no_begin", 32'(beg_cnt), 32'(b0));
        chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
